clock_cal_seq: RTL
==================

Name: clock_cal_seq

Overview:
Calibration sequencer for one tunable-clock delay-line controller instance. On request it latches calibration targets, holds the controller in reset for a settle period, then releases it. It watches the controller's 3-bit status (lock, at-end, at-top) through a synchronizer, confirms a stable lock, and retries on timeout or tap saturation. It reports done, locked or error to the system-side register block and runs entirely in the system clock domain.

Parameters:
SETTLE_CYCLES, 16, cycles ctl_resetn is held low per attempt (min 1)
LOCK_STABLE, 8, consecutive synced-lock cycles with at-end=0 required to declare lock
SAT_CYCLES, 32, consecutive synced at-end cycles in RUN that count as saturation
MAX_RETRY, 3, retries after the first attempt before FAIL (max 3, fits retry_cnt)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; ignored while busy=1
abort  in  1  return to IDLE, controller held in reset
cfg_ref_counter  in  16  reference-window length target
cfg_counter  in  16  expected clk-count target
cfg_init  in  9  controller init delay
cfg_timeout  in  24  per-attempt cycle limit; 0 = no timeout
ctl_status  in  3  raw controller status {lock, at_end, at_top}; asynchronous
ctl_resetn  out  1  controller reset, active-low
ctl_ref_counter  out  16  latched target
ctl_counter  out  16  latched target
ctl_init  out  9  latched init
busy  out  1  high in any state other than IDLE, LOCKED or FAIL
done  out  1  one-cycle pulse on entry to LOCKED or FAIL
locked  out  1  high while in LOCKED
error  out  1  high while in FAIL
err_code  out  2  00 none, 01 timeout, 10 saturated, 11 lock lost
retry_cnt  out  2  retries consumed in the current run

Behaviour:
- Reset state: IDLE. All outputs 0, including ctl_resetn, ctl_* config, err_code and retry_cnt. Synchronizer flops and all counters cleared.
- ctl_status passes through 2-flop synchronizers. All decisions use the synced bits: s_lock, s_end, s_top.
- IDLE: ctl_resetn=0. On start, latch cfg_* into ctl_* and the timeout register, clear retry_cnt and err_code, go to HOLD.
- LOCKED and FAIL also accept start with the same effect as IDLE.
- HOLD: ctl_resetn=0 for exactly SETTLE_CYCLES cycles, then go to RUN. ctl_resetn rises on the first RUN cycle.
- RUN: timer counts from 0.
  - s_lock=1 and s_end=0 -> CONFIRM.
  - s_end high for SAT_CYCLES consecutive cycles -> attempt fails with code 10.
  - Timer reaches the latched timeout (nonzero) -> attempt fails with code 01.
- CONFIRM: timer keeps counting.
  - LOCK_STABLE consecutive cycles of s_lock=1 and s_end=0 -> LOCKED, done pulse.
  - Any cycle violating that condition returns to RUN; the stability count clears and the timer does not.
  - Timeout applies here too.
- Attempt failure:
  - retry_cnt<MAX_RETRY: retry_cnt+1, go to HOLD. ctl_resetn drops the next cycle, which restarts the controller.
  - Otherwise: go to FAIL, latch err_code, done pulse.
- Simultaneous saturation and timeout in the same cycle: code 10.
- LOCKED: ctl_resetn stays 1.
  - s_lock=0 or s_end=1 for 2 consecutive cycles -> FAIL, err_code 11, done pulse. No retry from LOCKED.
- FAIL: ctl_resetn=0, error=1.
- Priority order: reset > abort > start > state logic.
  - abort in any state -> IDLE next cycle, ctl_resetn=0, err_code and retry_cnt preserved, no done pulse.
  - start in the same cycle as abort is ignored.
- Timer is 24-bit and saturates, never wraps.
- Config inputs are sampled only on accepted start. Changes mid-run have no effect.

Test Plan:
- Nominal lock: SETTLE_CYCLES=16, start with ctl_status=000. Drive lock=1 at RUN cycle 20 -> ctl_resetn rises 17 cycles after start. Lock is seen 2 cycles after driving. LOCKED and done follow after 8 stable cycles; retry_cnt=0, err_code=00.
- Timeout retries: cfg_timeout=100, lock never set -> 4 attempts (retry_cnt 1,2,3). ctl_resetn low 16 cycles between attempts. Ends in FAIL with err_code=01 and exactly one done pulse.
- Saturation: hold at_end=1 throughout RUN -> attempt fails after 32 synced cycles. Lock on the second attempt -> LOCKED with retry_cnt=1.
- Confirm glitch: lock=1 for 5 cycles, 0 for 1, then 1 steady -> CONFIRM aborts back to RUN. LOCKED is reached 8 cycles after the lock restores.
- Lock loss: in LOCKED, drop lock for 1 cycle -> stays LOCKED. Drop for 2 cycles -> FAIL, err_code=11, ctl_resetn=0.
- Abort/start collision: abort and start in the same RUN cycle -> IDLE, busy=0, no done pulse. A later start relatches new cfg values and reaches HOLD.

Source files
------------

// File: rtl/clock_cal_seq.sv
// clock_cal_seq: calibration sequencer for one tunable-clock delay-line
// controller. Latches targets on start, holds the controller in reset for a
// settle period, releases it, confirms a stable lock and retries on timeout
// or tap saturation. Everything runs in the system clock domain.
//
// Request protocol: start is a one-cycle request. It is accepted only when
// busy=0 (IDLE, LOCKED or FAIL) and abort is low. Completion is reported by
// a one-cycle done pulse together with locked/error/err_code.
module clock_cal_seq #(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_STABLE   = 8,
  parameter int SAT_CYCLES    = 32,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_ref_counter,
  input  logic [15:0] cfg_counter,
  input  logic [8:0]  cfg_init,
  input  logic [23:0] cfg_timeout,
  input  logic [2:0]  ctl_status,
  output logic        ctl_resetn,
  output logic [15:0] ctl_ref_counter,
  output logic [15:0] ctl_counter,
  output logic [8:0]  ctl_init,
  output logic        busy,
  output logic        done,
  output logic        locked,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [1:0]  retry_cnt,
  output logic [2:0]  dbg_state,
  output logic [2:0]  dbg_sync_status
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  // Counter widths only need to reach the terminal value minus one, since
  // each counter is cleared on the transition it triggers.
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SAT_W    = (SAT_CYCLES > 1)    ? $clog2(SAT_CYCLES)    : 1;
  localparam int STAB_W   = (LOCK_STABLE > 1)   ? $clog2(LOCK_STABLE)   : 1;

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_sync1;
  logic [2:0]          r_sync2;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [23:0]         r_timer;
  logic [23:0]         r_timeout;
  logic [SAT_W-1:0]    r_sat_cnt;
  logic [STAB_W-1:0]   r_stab_cnt;
  logic                r_lost_cnt;
  logic [1:0]          r_retry_cnt;
  logic [1:0]          r_err_code;
  logic                r_done;
  logic [15:0]         r_ref_counter;
  logic [15:0]         r_counter;
  logic [8:0]          r_init;

  logic       w_s_lock;
  logic       w_s_end;
  logic       w_good;
  logic       w_settle_done;
  logic       w_sat_hit;
  logic       w_timeout;
  logic       w_accept_start;
  logic       w_attempt_fail;
  logic [1:0] w_attempt_code;
  logic       w_retry;
  logic       w_final_fail;
  logic [1:0] w_final_code;

  assign w_s_lock      = r_sync2[2];
  assign w_s_end       = r_sync2[1];
  assign w_good        = w_s_lock & ~w_s_end;
  assign w_settle_done = (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign w_sat_hit     = w_s_end && (r_sat_cnt == SAT_W'(SAT_CYCLES - 1));
  assign w_timeout     = (r_timeout != 24'd0) && (r_timer >= r_timeout);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: abort beats start, start beats the per-state logic.
  always_comb begin
    w_next_state   = r_state;
    w_accept_start = 1'b0;
    w_attempt_fail = 1'b0;
    w_attempt_code = 2'b00;
    w_retry        = 1'b0;
    w_final_fail   = 1'b0;
    w_final_code   = 2'b00;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else if (start && (r_state == ST_IDLE || r_state == ST_LOCKED ||
                           r_state == ST_FAIL)) begin
      w_accept_start = 1'b1;
      w_next_state   = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_settle_done) w_next_state = ST_RUN;
        end
        ST_RUN: begin
          // Saturation wins over a timeout landing in the same cycle.
          if (w_sat_hit) begin
            w_attempt_fail = 1'b1;
            w_attempt_code = 2'b10;
          end else if (w_timeout) begin
            w_attempt_fail = 1'b1;
            w_attempt_code = 2'b01;
          end else if (w_good) begin
            w_next_state = (LOCK_STABLE <= 1) ? ST_LOCKED : ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (w_timeout) begin
            w_attempt_fail = 1'b1;
            w_attempt_code = 2'b01;
          end else if (!w_good) begin
            w_next_state = ST_RUN;
          end else if (r_stab_cnt == STAB_W'(LOCK_STABLE - 1)) begin
            w_next_state = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Lock lost for two consecutive cycles is terminal, never retried.
          if (!w_good && r_lost_cnt) begin
            w_final_fail = 1'b1;
            w_final_code = 2'b11;
            w_next_state = ST_FAIL;
          end
        end
        default: ;
      endcase
      if (w_attempt_fail) begin
        if (r_retry_cnt < 2'(MAX_RETRY)) begin
          w_retry      = 1'b1;
          w_next_state = ST_HOLD;
        end else begin
          w_final_fail = 1'b1;
          w_final_code = w_attempt_code;
          w_next_state = ST_FAIL;
        end
      end
    end
  end

  // Synchronizers, attempt counters, latched configuration and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1       <= 3'b000;
      r_sync2       <= 3'b000;
      r_settle_cnt  <= '0;
      r_timer       <= 24'd0;
      r_timeout     <= 24'd0;
      r_sat_cnt     <= '0;
      r_stab_cnt    <= '0;
      r_lost_cnt    <= 1'b0;
      r_retry_cnt   <= 2'b00;
      r_err_code    <= 2'b00;
      r_done        <= 1'b0;
      r_ref_counter <= 16'd0;
      r_counter     <= 16'd0;
      r_init        <= 9'd0;
    end else begin
      r_sync1 <= ctl_status;
      r_sync2 <= r_sync1;

      if (r_state == ST_HOLD && w_next_state == ST_HOLD) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end else begin
        r_settle_cnt <= '0;
      end

      // The timer spans RUN and CONFIRM together and saturates at all-ones.
      if ((r_state == ST_RUN || r_state == ST_CONFIRM) &&
          (w_next_state == ST_RUN || w_next_state == ST_CONFIRM)) begin
        if (r_timer != 24'hFF_FFFF) r_timer <= r_timer + 24'd1;
      end else begin
        r_timer <= 24'd0;
      end

      if (r_state == ST_RUN && w_next_state == ST_RUN && w_s_end) begin
        r_sat_cnt <= r_sat_cnt + 1'b1;
      end else begin
        r_sat_cnt <= '0;
      end

      // The RUN cycle that first sees a good lock counts as stable cycle one.
      if (w_next_state == ST_CONFIRM) begin
        r_stab_cnt <= (r_state == ST_CONFIRM) ? r_stab_cnt + 1'b1 : STAB_W'(1);
      end else begin
        r_stab_cnt <= '0;
      end

      r_lost_cnt <= (r_state == ST_LOCKED) && (w_next_state == ST_LOCKED) && !w_good;

      r_done <= ((w_next_state == ST_LOCKED) || (w_next_state == ST_FAIL)) &&
                (w_next_state != r_state);

      if (w_accept_start) begin
        r_ref_counter <= cfg_ref_counter;
        r_counter     <= cfg_counter;
        r_init        <= cfg_init;
        r_timeout     <= cfg_timeout;
        r_retry_cnt   <= 2'b00;
        r_err_code    <= 2'b00;
      end else begin
        if (w_retry) r_retry_cnt <= r_retry_cnt + 2'd1;
        if (w_final_fail) r_err_code <= w_final_code;
      end
    end
  end

  assign ctl_resetn      = (r_state == ST_RUN) || (r_state == ST_CONFIRM) ||
                           (r_state == ST_LOCKED);
  assign busy            = !((r_state == ST_IDLE) || (r_state == ST_LOCKED) ||
                             (r_state == ST_FAIL));
  assign done            = r_done;
  assign locked          = (r_state == ST_LOCKED);
  assign error           = (r_state == ST_FAIL);
  assign err_code        = r_err_code;
  assign retry_cnt       = r_retry_cnt;
  assign ctl_ref_counter = r_ref_counter;
  assign ctl_counter     = r_counter;
  assign ctl_init        = r_init;
  assign dbg_state       = r_state;
  assign dbg_sync_status = r_sync2;

endmodule
